// File: rtl/chirp_pkg.sv
// Shared definitions for the chirp phase sequencer.
//   state_t : sequencer states, encoding visible on state_dbg
//   MODE_*  : sweep mode codes on cfg_mode (code 3 is reserved and sweeps up)
//   leg_t   : direction of the current sweep leg
package chirp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_DWELL = 3'd3,
    ST_NEXT  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;

  typedef enum logic {
    LEG_RISE = 1'b0,
    LEG_FALL = 1'b1
  } leg_t;

endpackage

// File: rtl/chirp_dwell_timer.sv
// Dwell timer: loads a count, counts down to zero, then raises done for one
// cycle and goes inactive.
//   clk, rstn  : clock, synchronous active-low reset
//   load       : load load_value and start counting
//   load_value : number of idle cycles before done (0 = done on first cycle)
//   done       : one-cycle pulse when the loaded count has expired
module chirp_dwell_timer #(
  parameter int unsigned DWELL_W = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_value,
  output logic               done
);

  logic [DWELL_W-1:0] count;
  logic               active;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      count  <= load_value;
      active <= 1'b1;
    end else if (active) begin
      if (count == '0) begin
        active <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign done = active && (count == '0);

endmodule

// File: rtl/chirp_phase_sequencer.sv
// Chirp phase sequencer: steps a DDS phase increment linearly from a start
// value by a step for N words per leg (up, down or triangle sweep), with a
// dwell after each accepted word, and emits the words on an AXI4-Stream
// master. Repeats chirps while enable is high.
// Optional feature macro: CHIRP_PHASE_OFFSET_EN adds cfg_phase_offset, placed
// in tdata[TDATA_W/2 +: PHASE_W] for every word of the chirp.
//   clk, rstn            : clock, synchronous active-low reset
//   enable               : run chirps continuously while high
//   cfg_start_inc        : first phase increment
//   cfg_step             : increment delta per step
//   cfg_num_steps        : words per leg (0 treated as 1)
//   cfg_dwell            : idle cycles after each accepted word
//   cfg_mode             : 0 up, 1 down, 2 triangle, 3 up
//   m_axis_phase_*       : AXIS master to DDS phase channel
//   chirp_start          : pulse on first SEND cycle of a chirp
//   chirp_done           : pulse when a chirp completes
//   busy                 : high whenever not IDLE
//   state_dbg            : current state encoding
module chirp_phase_sequencer
  import chirp_pkg::*;
#(
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned STEP_CNT_W = 8,
  parameter int unsigned DWELL_W    = 32,
  parameter int unsigned TDATA_W    = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [PHASE_W-1:0]    cfg_start_inc,
  input  logic [PHASE_W-1:0]    cfg_step,
  input  logic [STEP_CNT_W-1:0] cfg_num_steps,
  input  logic [DWELL_W-1:0]    cfg_dwell,
  input  logic [1:0]            cfg_mode,
`ifdef CHIRP_PHASE_OFFSET_EN
  input  logic [PHASE_W-1:0]    cfg_phase_offset,
`endif
  output logic                  m_axis_phase_tvalid,
  input  logic                  m_axis_phase_tready,
  output logic [TDATA_W-1:0]    m_axis_phase_tdata,
  output logic                  chirp_start,
  output logic                  chirp_done,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  state_t                state, state_nxt;
  leg_t                  leg;
  logic [PHASE_W-1:0]    cur_inc;
  logic [PHASE_W-1:0]    step_r;
  logic [DWELL_W-1:0]    dwell_r;
  logic [STEP_CNT_W-1:0] idx;
  logic [STEP_CNT_W-1:0] last_idx;
  logic [STEP_CNT_W-1:0] n_m1;
  logic                  is_tri;
  logic                  start_pending;
  logic                  leg_end;
  logic                  chirp_end;
  logic                  dwell_done;
  logic                  handshake;
`ifdef CHIRP_PHASE_OFFSET_EN
  logic [PHASE_W-1:0]    offset_r;
`endif

  assign n_m1      = (cfg_num_steps == '0) ? '0 : cfg_num_steps - 1'b1;
  assign handshake = (state == ST_SEND) && m_axis_phase_tready;
  assign leg_end   = (idx == last_idx);
  // A finished rising leg in triangle mode turns around instead of ending,
  // unless the leg is a single word (N = 1 gives one word in every mode).
  assign chirp_end = leg_end && !(is_tri && (leg == LEG_RISE) && (last_idx != '0));

  chirp_dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_dwell (
    .clk       (clk),
    .rstn      (rstn),
    .load      (handshake),
    .load_value(dwell_r),
    .done      (dwell_done)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    m_axis_phase_tvalid = 1'b0;
    chirp_start         = 1'b0;
    chirp_done          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_LOAD;
      end
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: begin
        m_axis_phase_tvalid = 1'b1;
        chirp_start         = start_pending;
        if (m_axis_phase_tready) state_nxt = ST_DWELL;
      end
      ST_DWELL: begin
        if (dwell_done) state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        if (chirp_end) begin
          chirp_done = 1'b1;
          state_nxt  = enable ? ST_LOAD : ST_IDLE;
        end else begin
          state_nxt = ST_SEND;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      leg           <= LEG_RISE;
      cur_inc       <= '0;
      step_r        <= '0;
      dwell_r       <= '0;
      idx           <= '0;
      last_idx      <= '0;
      is_tri        <= 1'b0;
      start_pending <= 1'b0;
`ifdef CHIRP_PHASE_OFFSET_EN
      offset_r      <= '0;
`endif
    end else begin
      case (state)
        ST_LOAD: begin
          step_r        <= cfg_step;
          dwell_r       <= cfg_dwell;
          idx           <= '0;
          last_idx      <= n_m1;
          is_tri        <= (cfg_mode == MODE_TRI);
          start_pending <= 1'b1;
`ifdef CHIRP_PHASE_OFFSET_EN
          offset_r      <= cfg_phase_offset;
`endif
          if (cfg_mode == MODE_DOWN) begin
            leg     <= LEG_FALL;
            cur_inc <= cfg_start_inc + cfg_step * PHASE_W'(n_m1);
          end else begin
            leg     <= LEG_RISE;
            cur_inc <= cfg_start_inc;
          end
        end
        ST_SEND: start_pending <= 1'b0;
        ST_NEXT: begin
          if (!chirp_end) begin
            if (leg_end) begin
              // Triangle turnaround: the falling leg skips the peak, so it
              // is one word shorter than the rising leg.
              leg      <= LEG_FALL;
              idx      <= '0;
              last_idx <= last_idx - 1'b1;
              cur_inc  <= cur_inc - step_r;
            end else begin
              idx     <= idx + 1'b1;
              cur_inc <= (leg == LEG_RISE) ? cur_inc + step_r : cur_inc - step_r;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m_axis_phase_tdata              = '0;
    m_axis_phase_tdata[PHASE_W-1:0] = cur_inc;
`ifdef CHIRP_PHASE_OFFSET_EN
    m_axis_phase_tdata[TDATA_W/2 +: PHASE_W] = offset_r;
`endif
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_chirp_phase_sequencer.sv
// Self-checking bench for chirp_phase_sequencer (default parameters).
module tb_chirp_phase_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [31:0] cfg_start_inc;
  logic [31:0] cfg_step;
  logic [7:0]  cfg_num_steps;
  logic [31:0] cfg_dwell;
  logic [1:0]  cfg_mode;
`ifdef CHIRP_PHASE_OFFSET_EN
  logic [31:0] cfg_phase_offset;
  logic [31:0] snap_off;
`endif
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic        chirp_start;
  logic        chirp_done;
  logic        busy;
  logic [2:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  chirp_phase_sequencer #(
    .PHASE_W(32), .STEP_CNT_W(8), .DWELL_W(32), .TDATA_W(64)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .enable             (enable),
    .cfg_start_inc      (cfg_start_inc),
    .cfg_step           (cfg_step),
    .cfg_num_steps      (cfg_num_steps),
    .cfg_dwell          (cfg_dwell),
    .cfg_mode           (cfg_mode),
`ifdef CHIRP_PHASE_OFFSET_EN
    .cfg_phase_offset   (cfg_phase_offset),
`endif
    .m_axis_phase_tvalid(tvalid),
    .m_axis_phase_tready(tready),
    .m_axis_phase_tdata (tdata),
    .chirp_start        (chirp_start),
    .chirp_done         (chirp_done),
    .busy               (busy),
    .state_dbg          (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference sweep: word k of a chirp is start + m*step with m from the
  // sweep shape (up: k, down: N-1-k, triangle: k then 2N-2-k past the peak).
  function automatic int words_in(input logic [7:0] nraw, input logic [1:0] m);
    int n;
    n = (nraw == 0) ? 1 : int'(nraw);
    return (m == 2'd2) ? 2 * n - 1 : n;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] s, input logic [31:0] st,
                                          input logic [7:0] nraw, input logic [1:0] m,
                                          input int k);
    int n;
    logic [31:0] mult;
    n = (nraw == 0) ? 1 : int'(nraw);
    if (m == 2'd1)                mult = 32'(n - 1 - k);
    else if (m == 2'd2 && k >= n) mult = 32'(2 * n - 2 - k);
    else                          mult = 32'(k);
    return s + st * mult;
  endfunction

  // Inputs as seen at the most recent rising edge.
  int          cyc = 0;
  logic        rstn_s = 1'b0;
  logic        snap_en = 1'b0;
  logic [31:0] snap_start, snap_step, snap_dwell;
  logic [7:0]  snap_n;
  logic [1:0]  snap_mode;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rstn_s     <= rstn;
    snap_en    <= enable;
    snap_start <= cfg_start_inc;
    snap_step  <= cfg_step;
    snap_n     <= cfg_num_steps;
    snap_dwell <= cfg_dwell;
    snap_mode  <= cfg_mode;
`ifdef CHIRP_PHASE_OFFSET_EN
    snap_off   <= cfg_phase_offset;
`endif
  end

  logic [31:0] exp_q[$];
  logic [31:0] obs_log[$];
  logic [31:0] exp_hi;
  logic [63:0] prev_tdata;
  logic        in_chirp   = 1'b0;
  logic        prev_stall = 1'b0;
  int          last_hs    = -1;
  int          exp_done   = -1;
  int          done_cyc   = -1;
  int          exp_start  = -1;
  int          dwell_m    = 0;
  int          start_cnt  = 0;
  int          done_cnt   = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (!rstn_s) begin
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start", 64'(chirp_start), 64'd0);
        chk("rst_done", 64'(chirp_done), 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        exp_q.delete();
        in_chirp = 1'b0; prev_stall = 1'b0;
        last_hs = -1; exp_done = -1; done_cyc = -1; exp_start = -1;
      end else begin
        if (done_cyc >= 0 && cyc == done_cyc + 1) begin
          chk("after_done_busy", 64'(busy), 64'(snap_en));
          if (snap_en) exp_start = cyc + 1;
        end
        if (cyc == exp_start) chk("b2b_start", 64'(chirp_start), 64'd1);
        if (chirp_start) begin
          chk("start_in_chirp", 64'(in_chirp), 64'd0);
          chk("start_valid", 64'(tvalid), 64'd1);
          exp_q.delete();
          for (int k = 0; k < words_in(snap_n, snap_mode); k++)
            exp_q.push_back(word_at(snap_start, snap_step, snap_n, snap_mode, k));
`ifdef CHIRP_PHASE_OFFSET_EN
          exp_hi = snap_off;
`else
          exp_hi = 32'd0;
`endif
          dwell_m  = int'(snap_dwell);
          in_chirp = 1'b1;
          last_hs  = -1;
          start_cnt++;
        end
        if (in_chirp) chk("busy_in_chirp", 64'(busy), 64'd1);
        if (tvalid) begin
          chk("valid_in_chirp", 64'(in_chirp), 64'd1);
          if (prev_stall) chk("hold_tdata", tdata, prev_tdata);
          else if (last_hs >= 0) chk("word_spacing", 64'(cyc - last_hs), 64'(dwell_m + 3));
          chk("tdata_hi", 64'(tdata[63:32]), 64'(exp_hi));
          if (tready) begin
            chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("word", 64'(tdata[31:0]), 64'(exp_q.pop_front()));
            obs_log.push_back(tdata[31:0]);
            last_hs = cyc;
            if (exp_q.size() == 0) exp_done = cyc + dwell_m + 2;
          end
          prev_stall = !tready;
          prev_tdata = tdata;
        end else begin
          if (prev_stall) chk("valid_dropped", 64'(tvalid), 64'd1);
          prev_stall = 1'b0;
        end
        if (chirp_done || cyc == exp_done) begin
          chk("done_pulse", 64'(chirp_done), 64'd1);
          chk("done_time", 64'(cyc), 64'(exp_done));
          chk("done_words_left", 64'(exp_q.size()), 64'd0);
          in_chirp = 1'b0;
          done_cyc = cyc;
          exp_done = -1;
          done_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 start_cnt>=t, 1 done_cnt>=t, 2 idle, 3 state_dbg==t, 4 log>=t with tvalid
  task automatic wait_cond(input string name, input int which, input int t, input int limit);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      case (which)
        0: ok = (start_cnt >= t);
        1: ok = (done_cnt >= t);
        2: ok = !busy && !in_chirp;
        3: ok = (int'(state_dbg) == t);
        default: ok = (obs_log.size() >= t) && tvalid;
      endcase
      if (!ok) tick();
    end
    chk({"wait_", name}, 64'(ok), 64'd1);
  endtask

  task automatic set_cfg(input logic [31:0] s, input logic [31:0] st, input logic [7:0] n,
                         input logic [31:0] d, input logic [1:0] m);
    cfg_start_inc = s; cfg_step = st; cfg_num_steps = n; cfg_dwell = d; cfg_mode = m;
`ifdef CHIRP_PHASE_OFFSET_EN
    cfg_phase_offset = $urandom;
`endif
  endtask

  task automatic run_chirps(input string name, input int n);
    int s0, d0;
    s0 = start_cnt; d0 = done_cnt;
    obs_log.delete();
    enable = 1'b1;
    wait_cond({name, "_start"}, 0, s0 + n, 3000);
    enable = 1'b0;
    wait_cond({name, "_done"}, 1, d0 + n, 3000);
    wait_cond({name, "_idle"}, 2, 0, 50);
    chk({name, "_starts"}, 64'(start_cnt - s0), 64'(n));
    chk({name, "_dones"}, 64'(done_cnt - d0), 64'(n));
  endtask

  task automatic check_log(input string name, input int n, input logic [31:0] e [10]);
    chk({name, "_count"}, 64'(obs_log.size()), 64'(n));
    for (int i = 0; i < n && i < obs_log.size(); i++)
      chk($sformatf("%s_w%0d", name, i), 64'(obs_log[i]), 64'(e[i]));
  endtask

  logic [31:0] e [10];

  initial begin
    rstn = 1'b0; enable = 1'b0; tready = 1'b1;
    set_cfg(32'd0, 32'd0, 8'd1, 32'd0, 2'd0);

    // Hand-computed points of the reference sweep.
    chk("model_tri_len", 64'(words_in(8'd3, 2'd2)), 64'd5);
    chk("model_tri_w3", 64'(word_at(32'd0, 32'd5, 8'd3, 2'd2, 3)), 64'd5);
    chk("model_down_w0", 64'(word_at(32'd100, 32'd10, 8'd3, 2'd1, 0)), 64'd120);
    chk("model_wrap_w1", 64'(word_at(32'hFFFFFFF0, 32'h20, 8'd2, 2'd0, 1)), 64'h10);
    chk("model_n0_len", 64'(words_in(8'd0, 2'd2)), 64'd1);
    chk("model_rsv_w2", 64'(word_at(32'd7, 32'd3, 8'd4, 2'd3, 2)), 64'd13);

    repeat (3) tick();
    rstn = 1'b1;
    tick();

    set_cfg(32'h186A0, 32'h186A0, 8'd4, 32'd2, 2'd0);
    run_chirps("up", 1);
    e = '{32'h186A0, 32'h30D40, 32'h493E0, 32'h61A80, 0, 0, 0, 0, 0, 0};
    check_log("up", 4, e);

    set_cfg(32'd100, 32'd10, 8'd3, 32'd1, 2'd1);
    run_chirps("down", 1);
    e = '{32'd120, 32'd110, 32'd100, 0, 0, 0, 0, 0, 0, 0};
    check_log("down", 3, e);

    set_cfg(32'd0, 32'd5, 8'd3, 32'd0, 2'd2);
    run_chirps("tri", 2);
    e = '{32'd0, 32'd5, 32'd10, 32'd5, 32'd0, 32'd0, 32'd5, 32'd10, 32'd5, 32'd0};
    check_log("tri", 10, e);

    // Backpressure on word index 2.
    set_cfg(32'd1000, 32'd7, 8'd4, 32'd1, 2'd0);
    obs_log.delete();
    enable = 1'b1;
    wait_cond("bp_word2", 4, 2, 500);
    enable = 1'b0;
    tready = 1'b0;
    repeat (7) tick();
    tready = 1'b1;
    wait_cond("bp_idle", 2, 0, 500);
    e = '{32'd1000, 32'd1007, 32'd1014, 32'd1021, 0, 0, 0, 0, 0, 0};
    check_log("bp", 4, e);

    set_cfg(32'hFFFFFFF0, 32'h20, 8'd2, 32'd3, 2'd0);
    run_chirps("wrap", 1);
    e = '{32'hFFFFFFF0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0};
    check_log("wrap", 2, e);

    set_cfg(32'd9, 32'd4, 8'd1, 32'd0, 2'd2);
    run_chirps("tri_n1", 1);
    e = '{32'd9, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_log("tri_n1", 1, e);

    // Reset in the middle of DWELL.
    set_cfg(32'd50, 32'd1, 8'd8, 32'd6, 2'd0);
    enable = 1'b1;
    wait_cond("rd_dwell", 3, 3, 500);
    rstn = 1'b0; enable = 1'b0;
    tick();
    chk("rd_tvalid", 64'(tvalid), 64'd0);
    chk("rd_state", 64'(state_dbg), 64'd0);
    rstn = 1'b1;
    tick();
    set_cfg(32'h777, 32'd3, 8'd2, 32'd0, 2'd0);
    run_chirps("rd_restart", 1);
    e = '{32'h777, 32'h77A, 0, 0, 0, 0, 0, 0, 0, 0};
    check_log("rd_restart", 2, e);

    // Reset while a word is stalled in SEND.
    set_cfg(32'd9, 32'd1, 8'd3, 32'd0, 2'd0);
    tready = 1'b0;
    enable = 1'b1;
    wait_cond("rs_send", 3, 2, 500);
    repeat (2) tick();
    rstn = 1'b0; enable = 1'b0;
    tick();
    chk("rs_tvalid", 64'(tvalid), 64'd0);
    chk("rs_state", 64'(state_dbg), 64'd0);
    rstn = 1'b1; tready = 1'b1;
    tick();
    set_cfg(32'hABC, 32'd2, 8'd1, 32'd1, 2'd1);
    run_chirps("rs_restart", 1);
    e = '{32'hABC, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_log("rs_restart", 1, e);

    // Random sweeps with random backpressure; config changes land mid-chirp.
    for (int r = 0; r < 40; r++) begin
      set_cfg($urandom, $urandom, 8'($urandom_range(0, 6)), 32'($urandom_range(0, 4)),
              2'($urandom_range(0, 3)));
      enable = ($urandom_range(0, 4) != 0);
      for (int c = 0; c < 60; c++) begin
        tready = ($urandom_range(0, 9) < 7);
        tick();
      end
    end
    enable = 1'b0;
    tready = 1'b1;
    wait_cond("rand_idle", 2, 0, 2000);
    chk("rand_chirps_seen", 64'(start_cnt > 20), 64'd1);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chirp_phase_sequencer.md
Name: chirp_phase_sequencer

Overview:
Parametrised chirp generator feeding the phase-increment channel of the DDS compiler over AXI4-Stream. It steps the phase increment linearly from a runtime start value by a runtime step, for a runtime step count and dwell. It supports up, down and triangle sweeps and auto-repeats while enabled. It is the successor of the fixed-constant chirp state machine. It sits between the control/register logic and the DDS s_axis_phase port.

Parameters:
PHASE_W, 32, width of phase increment and of step.
STEP_CNT_W, 8, width of step-count config and internal step index.
DWELL_W, 32, width of dwell config and dwell counter.
TDATA_W, 64, AXIS tdata width; must be a multiple of 8 and at least 2*PHASE_W.

Ports:
clk  in  1  system clock
rstn  in  1  reset; synchronous, active-low
enable  in  1  level; high = run chirps continuously
cfg_start_inc  in  PHASE_W  first phase increment
cfg_step  in  PHASE_W  increment delta per step
cfg_num_steps  in  STEP_CNT_W  words per leg (0 treated as 1)
cfg_dwell  in  DWELL_W  idle cycles after each accepted word
cfg_mode  in  2  0 = up, 1 = down, 2 = triangle, 3 = reserved (behaves as up)
m_axis_phase_tvalid  out  1  AXIS valid to DDS
m_axis_phase_tready  in  1  AXIS ready from DDS
m_axis_phase_tdata  out  TDATA_W  {zero pad, phase increment in [PHASE_W-1:0]}
chirp_start  out  1  one-cycle pulse at the first word of each chirp
chirp_done  out  1  one-cycle pulse when a chirp completes
busy  out  1  high in every state except IDLE
state_dbg  out  3  current state encoding

Behaviour:
- Reset (rstn = 0 at a clk edge): state IDLE; tvalid, chirp_start, chirp_done and busy = 0; tdata = 0; step index and dwell counter = 0. Reset applies mid-handshake: tvalid drops the next cycle and the word is abandoned.
- States: IDLE(0), LOAD(1), SEND(2), DWELL(3), NEXT(4).
- IDLE: when enable = 1, go to LOAD.
- LOAD: sample all cfg_* into shadow registers. cur_inc = start (up/triangle) or start + (N-1)*step (down). Set leg = rising, except down mode which is falling. Index = 0. Go to SEND. cfg changes outside LOAD have no effect on a running chirp.
- SEND: tvalid = 1 with tdata = cur_inc.
  - tdata and tvalid are held stable until tready = 1; tvalid never drops without a handshake.
  - chirp_start pulses on the first SEND cycle of index 0 of leg 1.
  - On the handshake edge: go to DWELL and load the dwell counter with cfg_dwell; tvalid goes low the next cycle.
- DWELL: count down to 0, then go to NEXT. With dwell = 0, NEXT follows the handshake immediately; minimum word spacing is 3 cycles.
- NEXT: step the sweep.
  - If the leg is not finished: index += 1; cur_inc += step (rising) or -= step (falling); go to SEND.
  - Triangle mode, end of the rising leg: switch to falling; index = 0; cur_inc -= step. The peak is not repeated. The falling leg emits N-1 words ending at start, so a triangle chirp is 2N-1 words in total.
  - Chirp complete: pulse chirp_done. If enable = 1, go to LOAD (back-to-back chirps, resampled config); otherwise go to IDLE.
- enable deasserted mid-chirp: the current chirp finishes; there is no abort except reset.
- Arithmetic: unsigned modulo 2^PHASE_W; overflow and underflow wrap silently. tdata[TDATA_W-1:PHASE_W] = 0.
- N = 1: one word per chirp in every mode.

Optional Feature:
Macro CHIRP_PHASE_OFFSET_EN.
- Defined: adds input cfg_phase_offset [PHASE_W], sampled in LOAD. Drives tdata[TDATA_W/2+PHASE_W-1:TDATA_W/2] for every word of the chirp, matching the DDS offset field. Remaining bits are 0.
- Undefined: the port is absent and the upper half of tdata is 0.

Decomposition:
- Shared package chirp_pkg: state encodings, mode constants MODE_UP/MODE_DOWN/MODE_TRI, leg direction constants.
- One sub-module chirp_dwell_timer (DWELL_W): load/start, count down, done pulse.
- Sequencing and arithmetic stay in the top module.

Test Plan:
- Up, start = 0x186A0, step = 0x186A0, N = 4, dwell = 2, tready = 1 -> tdata 0x186A0, 0x30D40, 0x493E0, 0x61A80; 5-cycle word spacing; one chirp_start and one chirp_done per chirp.
- Down, start = 100, step = 10, N = 3 -> 120, 110, 100, then chirp_done.
- Triangle, start = 0, step = 5, N = 3 -> 0, 5, 10, 5, 0 (5 words); second chirp repeats while enable = 1.
- Backpressure: tready low 7 cycles during word 2 -> tvalid stays high and tdata stays constant; exactly one transfer per word.
- Wrap: start = 0xFFFFFFF0, step = 0x20, up, N = 2 -> 0xFFFFFFF0, 0x00000010.
- rstn low mid-DWELL and mid-SEND, enable then dropped -> tvalid = 0 the next cycle and state IDLE. Restart resamples config and the first word equals the new start.
